// File: rtl/shape_sfr_master.sv
`default_nettype none
// ============================================================================
// Module   : shape_sfr_master
// Purpose  : Turns upstream shape/operation commands into SFR writes towards
//            a shape processor. Optionally verifies each write by reading the
//            register back, retrying a bounded number of times on mismatch.
//            Reports one completion status per command.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_RETRIES   retries after a readback mismatch (0..7)
//   READBACK_EN   1 = verify each write by readback, 0 = skip readback
// Compile-time option
//   SHAPE_SFR_MASTER_LEGAL_CHECK_EN  when defined, illegal shape/operation
//                 commands are answered with ILLEGAL without any bus access
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_shape[1:0]            01 rectangle, 10 triangle
//   cmd_operation[4:0]        00000, 00001, 01000, 10000, 10001 legal
//   write, write_data[31:0]   SFR write strobe and word
//   read, read_data[31:0]     SFR read strobe, word valid the cycle after read
//   error                     bus error, valid the cycle after a strobe
//   resp_valid/resp_ready     completion handshake
//   resp_status[1:0]          00 OK, 01 BUS_ERROR, 10 MISMATCH, 11 ILLEGAL
//   resp_attempts[2:0]        write attempts used for the command
// ============================================================================
module shape_sfr_master #(
   parameter int MAX_RETRIES = 2,
   parameter int READBACK_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_shape,
   input  logic [4:0]  cmd_operation,
   output logic        write,
   output logic [31:0] write_data,
   output logic        read,
   input  logic [31:0] read_data,
   input  logic        error,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [1:0]  resp_status,
   output logic [2:0]  resp_attempts
);

   localparam logic [1:0] STATUS_OK       = 2'b00;
   localparam logic [1:0] STATUS_BUS_ERR  = 2'b01;
   localparam logic [1:0] STATUS_MISMATCH = 2'b10;
`ifdef SHAPE_SFR_MASTER_LEGAL_CHECK_EN
   localparam logic [1:0] STATUS_ILLEGAL  = 2'b11;
`endif

   localparam logic [2:0] MAX_RETRY_CNT = 3'(MAX_RETRIES);
   localparam logic [2:0] ATTEMPT_SAT   = 3'd7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      WR_RSP = 3'd2,
      RD     = 3'd3,
      RD_RSP = 3'd4,
      RESP   = 3'd5
   } state_t;

   state_t state;

   // SFR word layout: shape in [17:16], operation in [4:0]
   logic [31:0] cmd_word;
   assign cmd_word = {14'b0, cmd_shape, 11'b0, cmd_operation};

`ifdef SHAPE_SFR_MASTER_LEGAL_CHECK_EN
   logic cmd_legal;
   always_comb begin
      cmd_legal = 1'b0;
      if ((cmd_shape == 2'b01) || (cmd_shape == 2'b10)) begin
         case (cmd_operation)
            5'b00000, 5'b00001, 5'b01000, 5'b10000, 5'b10001: cmd_legal = 1'b1;
            default:                                          cmd_legal = 1'b0;
         endcase
      end
   end
`endif

   // A retry is allowed only while the counter has room to count it; with
   // MAX_RETRIES=7 the saturated counter would otherwise retry forever.
   logic retry_ok;
   assign retry_ok = (resp_attempts <= MAX_RETRY_CNT) && (resp_attempts != ATTEMPT_SAT);

   // resp_attempts doubles as the live attempt counter: it is cleared on
   // accept and not touched while a response is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         write         <= 1'b0;
         read          <= 1'b0;
         write_data    <= 32'h0;
         resp_valid    <= 1'b0;
         resp_status   <= STATUS_OK;
         resp_attempts <= 3'd0;
      end else begin
         // strobes are single-cycle pulses unless re-armed below
         write <= 1'b0;
         read  <= 1'b0;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready     <= 1'b0;
                  write_data    <= cmd_word;
                  resp_attempts <= 3'd0;
`ifdef SHAPE_SFR_MASTER_LEGAL_CHECK_EN
                  if (!cmd_legal) begin
                     state       <= RESP;
                     resp_valid  <= 1'b1;
                     resp_status <= STATUS_ILLEGAL;
                  end else begin
                     state <= WR;
                     write <= 1'b1;
                  end
`else
                  state <= WR;
                  write <= 1'b1;
`endif
               end
            end

            WR: begin
               state <= WR_RSP;
               if (resp_attempts != ATTEMPT_SAT) begin
                  resp_attempts <= resp_attempts + 3'd1;
               end
            end

            WR_RSP: begin
               if (error) begin
                  state       <= RESP;
                  resp_valid  <= 1'b1;
                  resp_status <= STATUS_BUS_ERR;
               end else if (READBACK_EN != 0) begin
                  state <= RD;
                  read  <= 1'b1;
               end else begin
                  state       <= RESP;
                  resp_valid  <= 1'b1;
                  resp_status <= STATUS_OK;
               end
            end

            RD: begin
               state <= RD_RSP;
            end

            RD_RSP: begin
               if (error) begin
                  state       <= RESP;
                  resp_valid  <= 1'b1;
                  resp_status <= STATUS_BUS_ERR;
               end else if (read_data == write_data) begin
                  state       <= RESP;
                  resp_valid  <= 1'b1;
                  resp_status <= STATUS_OK;
               end else if (retry_ok) begin
                  // RD_RSP is the quiet cycle separating read from write
                  state <= WR;
                  write <= 1'b1;
               end else begin
                  state       <= RESP;
                  resp_valid  <= 1'b1;
                  resp_status <= STATUS_MISMATCH;
               end
            end

            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  cmd_ready  <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shape_sfr_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shape_sfr_master
// Purpose  : Self-checking bench for shape_sfr_master with a behavioural SFR
//            responder and a queue of expected completion results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shape_sfr_master;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_BUS = 2'b01;
   localparam logic [1:0] ST_MIS = 2'b10;
   localparam logic [1:0] ST_ILL = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_shape = 2'b00;
   logic [4:0]  cmd_operation = 5'b0;
   logic        write;
   logic [31:0] write_data;
   logic        read;
   logic [31:0] read_data = 32'h0;
   logic        error = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [1:0]  resp_status;
   logic [2:0]  resp_attempts;

   shape_sfr_master #(
      .MAX_RETRIES (2),
      .READBACK_EN (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_shape     (cmd_shape),
      .cmd_operation (cmd_operation),
      .write         (write),
      .write_data    (write_data),
      .read          (read),
      .read_data     (read_data),
      .error         (error),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_status   (resp_status),
      .resp_attempts (resp_attempts)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0] status;
      logic [2:0] attempts;
   } exp_t;
   exp_t exp_q[$];

   // SFR responder: stores written words, answers one cycle after a strobe
   logic        err_wr  = 1'b0;
   logic        err_rd  = 1'b0;
   logic        zero_rd = 1'b0;
   logic [31:0] stored  = 32'h0;

   always @(posedge clk) begin
      error     <= (write && err_wr) || (read && err_rd);
      read_data <= read ? (zero_rd ? 32'h0 : stored) : 32'h0;
      if (write) stored <= write_data;
   end

   // strobe monitor
   int          wr_cnt  = 0;
   int          rd_cnt  = 0;
   int          viol    = 0;
   logic [31:0] last_wr = 32'h0;
   logic        prev_wr = 1'b0;
   logic        prev_rd = 1'b0;

   always @(negedge clk) begin
      if (write) begin
         wr_cnt  <= wr_cnt + 1;
         last_wr <= write_data;
      end
      if (read) rd_cnt <= rd_cnt + 1;
      if ((write && read) || (write && prev_rd) || (read && prev_wr)) viol <= viol + 1;
      prev_wr <= write;
      prev_rd <= read;
   end

   task automatic wait_ready(input string name, output logic ok);
      int cyc;
      cyc = 0;
      while (!cmd_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      ok = cmd_ready;
      total++;
      if (!ok) begin
         $display("FAIL %s cmd_ready timeout: got 0 want 1", name);
         bad++;
      end
   endtask

   // Issue one command and complete it; expected results go through exp_q.
   task automatic do_cmd(input string name, input logic [1:0] shape, input logic [4:0] op,
                         input logic [1:0] exp_status, input logic [2:0] exp_att,
                         input int exp_wr, input int exp_rd, input logic [31:0] exp_word,
                         input int exp_lat, input int hold);
      int         wr0, rd0, cyc;
      logic       ok;
      logic [1:0] st0;
      logic [2:0] at0;
      exp_t       e;
      wait_ready(name, ok);
      if (!ok) return;
      e.status   = exp_status;
      e.attempts = exp_att;
      exp_q.push_back(e);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      cmd_valid     = 1'b1;
      cmd_shape     = shape;
      cmd_operation = op;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (!resp_valid) begin
         $display("FAIL %s resp_valid timeout: got 0 want 1", name);
         bad++;
         void'(exp_q.pop_front());
         return;
      end
      if (exp_lat > 0) begin
         total++;
         if (cyc !== exp_lat) begin
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
            bad++;
         end
      end
      st0 = resp_status;
      at0 = resp_attempts;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         total++;
         if (resp_valid !== 1'b1 || resp_status !== st0 || resp_attempts !== at0 || cmd_ready !== 1'b0) begin
            $display("FAIL %s hold%0d: got v=%b s=%b a=%0d rdy=%b want v=1 s=%b a=%0d rdy=0",
                     name, i, resp_valid, resp_status, resp_attempts, cmd_ready, st0, at0);
            bad++;
         end
      end
      st0 = resp_status;
      at0 = resp_attempts;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (st0 !== e.status || at0 !== e.attempts) begin
         $display("FAIL %s response: got status=%b attempts=%0d want status=%b attempts=%0d",
                  name, st0, at0, e.status, e.attempts);
         bad++;
      end
      total++;
      if (resp_valid !== 1'b0) begin
         $display("FAIL %s resp_valid after handshake: got %b want 0", name, resp_valid);
         bad++;
      end
      total++;
      if ((wr_cnt - wr0) !== exp_wr || (rd_cnt - rd0) !== exp_rd) begin
         $display("FAIL %s strobes: got writes=%0d reads=%0d want writes=%0d reads=%0d",
                  name, wr_cnt - wr0, rd_cnt - rd0, exp_wr, exp_rd);
         bad++;
      end
      if (exp_wr > 0) begin
         total++;
         if (last_wr !== exp_word) begin
            $display("FAIL %s write_data: got %h want %h", name, last_wr, exp_word);
            bad++;
         end
      end
   endtask

   task automatic test_reset;
      logic ok;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (cmd_ready !== 1'b0 || write !== 1'b0 || read !== 1'b0 || write_data !== 32'h0 ||
          resp_valid !== 1'b0 || resp_status !== 2'b00 || resp_attempts !== 3'd0) begin
         $display("FAIL reset_values: got rdy=%b wr=%b rd=%b wd=%h v=%b s=%b a=%0d want all zero",
                  cmd_ready, write, read, write_data, resp_valid, resp_status, resp_attempts);
         bad++;
      end
      rst = 1'b0;
      wait_ready("reset_ready", ok);
   endtask

   task automatic test_ok;
      err_wr = 1'b0; err_rd = 1'b0; zero_rd = 1'b0;
      do_cmd("ok_rect_op1", 2'b01, 5'b00001, ST_OK, 3'd1, 1, 1, 32'h0001_0001, 4, 5);
   endtask

   task automatic test_bus_error;
      err_wr = 1'b1; err_rd = 1'b0; zero_rd = 1'b0;
      do_cmd("wr_bus_error", 2'b10, 5'b10001, ST_BUS, 3'd1, 1, 0, 32'h0002_0011, 0, 2);
      err_wr = 1'b0; err_rd = 1'b1;
      do_cmd("rd_bus_error", 2'b01, 5'b01000, ST_BUS, 3'd1, 1, 1, 32'h0001_0008, 0, 0);
      err_rd = 1'b0;
   endtask

   task automatic test_mismatch;
      zero_rd = 1'b1;
      do_cmd("mismatch_retry", 2'b10, 5'b10000, ST_MIS, 3'd3, 3, 3, 32'h0002_0010, 0, 1);
      zero_rd = 1'b0;
   endtask

   task automatic test_illegal;
      zero_rd = 1'b1;
`ifdef SHAPE_SFR_MASTER_LEGAL_CHECK_EN
      do_cmd("illegal_cmd", 2'b11, 5'b00000, ST_ILL, 3'd0, 0, 0, 32'h0, 0, 1);
`else
      do_cmd("illegal_cmd", 2'b11, 5'b00000, ST_MIS, 3'd3, 3, 3, 32'h0003_0000, 0, 1);
`endif
      zero_rd = 1'b0;
   endtask

   task automatic test_back_to_back;
      do_cmd("b2b_first",  2'b10, 5'b00000, ST_OK, 3'd1, 1, 1, 32'h0002_0000, 4, 0);
      do_cmd("b2b_second", 2'b01, 5'b10000, ST_OK, 3'd1, 1, 1, 32'h0001_0010, 4, 0);
   endtask

   task automatic test_reset_abort;
      int   cyc;
      logic ok;
      logic saw;
      wait_ready("abort_rd_ready", ok);
      if (!ok) return;
      cmd_valid = 1'b1; cmd_shape = 2'b01; cmd_operation = 5'b01000;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while (!read && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (read !== 1'b1) begin
         $display("FAIL abort_rd read timeout: got %b want 1", read);
         bad++;
      end
      @(posedge clk); #1;   // now in RD_RSP
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (resp_valid !== 1'b0 || write !== 1'b0 || read !== 1'b0 || cmd_ready !== 1'b0) begin
         $display("FAIL abort_rd reset: got v=%b wr=%b rd=%b rdy=%b want 0 0 0 0",
                  resp_valid, write, read, cmd_ready);
         bad++;
      end
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_valid) saw = 1'b1;
      end
      total++;
      if (saw !== 1'b0 || cmd_ready !== 1'b1) begin
         $display("FAIL abort_rd idle: got saw_valid=%b rdy=%b want 0 1", saw, cmd_ready);
         bad++;
      end

      // response pending in RESP is discarded by reset
      wait_ready("abort_resp_ready", ok);
      if (!ok) return;
      cmd_valid = 1'b1; cmd_shape = 2'b10; cmd_operation = 5'b00001;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (resp_valid !== 1'b1) begin
         $display("FAIL abort_resp valid timeout: got %b want 1", resp_valid);
         bad++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (resp_valid) saw = 1'b1;
      end
      total++;
      if (saw !== 1'b0 || resp_status !== 2'b00 || resp_attempts !== 3'd0) begin
         $display("FAIL abort_resp discard: got saw_valid=%b s=%b a=%0d want 0 00 0",
                  saw, resp_status, resp_attempts);
         bad++;
      end
   endtask

   task automatic test_protocol;
      total++;
      if (viol !== 0) begin
         $display("FAIL strobe_spacing: got violations=%0d want 0", viol);
         bad++;
      end
      total++;
      if (exp_q.size() !== 0) begin
         $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
         bad++;
      end
   endtask

   initial begin
      test_reset();
      test_ok();
      test_bus_error();
      test_mismatch();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      test_ok();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
